// File: rtl/lane_serializer_if.sv
// Load / beat handshake bundle for lane_serializer: wide vector load side
// plus the narrow slice-per-beat output side.
interface lane_serializer_if #(
  parameter int WIDTH = 32,
  parameter int LANES = 64,
  parameter int SLICE = 16
);
  logic                     in_valid;
  logic                     in_ready;
  logic [LANES*WIDTH-1:0]   in_data;
  logic [LANES-1:0]         in_mask;
  logic                     flush;
  logic                     out_valid;
  logic                     out_ready;
  logic [SLICE*WIDTH-1:0]   out_data;
  logic [SLICE-1:0]         out_mask;
  logic [(((LANES/SLICE) > 1) ? $clog2(LANES/SLICE) : 1)-1:0] out_idx;
  logic                     out_last;
  logic                     empty_drop;

  modport master (
    output in_valid, in_data, in_mask, flush, out_ready,
    input  in_ready, out_valid, out_data, out_mask, out_idx, out_last, empty_drop
  );

  modport slave (
    input  in_valid, in_data, in_mask, flush, out_ready,
    output in_ready, out_valid, out_data, out_mask, out_idx, out_last, empty_drop
  );
endinterface

// File: rtl/lane_serializer.sv
// Wide-to-narrow wavefront serializer: captures LANES lanes plus exec mask in
// one cycle and emits SLICE lanes per beat, optionally skipping empty slices.
module lane_serializer #(
  parameter int WIDTH      = 32,
  parameter int LANES      = 64,
  parameter int SLICE      = 16,
  parameter int SKIP_EMPTY = 1
) (
  input logic             clk,
  input logic             rst,
  lane_serializer_if.slave bus
);
  localparam int DEPTH = LANES / SLICE;
  localparam int IDXW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                 r_state;
  logic                   r_out_valid;
  logic                   r_out_last;
  logic                   r_empty_drop;
  logic [IDXW-1:0]        r_idx;
  logic [LANES*WIDTH-1:0] r_data;
  logic [LANES-1:0]       r_mask;

  logic [DEPTH-1:0]       w_in_sel;
  logic [DEPTH-1:0]       w_r_sel;
  logic [IDXW:0]          w_in_pick;
  logic [IDXW:0]          w_nxt_pick;
  logic                   w_in_found;
  logic                   w_nxt_found;
  logic [IDXW-1:0]        w_in_idx;
  logic [IDXW-1:0]        w_nxt_idx;
  logic                   w_fire;
  logic                   w_in_ready;
  logic                   w_load;

  // Priority search: lowest qualifying slice at or above start, {found, idx}.
  function automatic logic [IDXW:0] pick(input logic [DEPTH-1:0] sel, input int start);
    logic [IDXW:0] r;
    r = '0;
    for (int d = DEPTH - 1; d >= 0; d--) begin
      if (sel[d] && (d >= start)) r = {1'b1, IDXW'(d)};
    end
    return r;
  endfunction

  function automatic logic any_after(input logic [DEPTH-1:0] sel, input int idx);
    logic r;
    r = 1'b0;
    for (int d = 0; d < DEPTH; d++) begin
      if (sel[d] && (d > idx)) r = 1'b1;
    end
    return r;
  endfunction

  // Without skipping every slice qualifies, so the same search walks 0..DEPTH-1.
  always_comb begin
    w_in_sel = '1;
    w_r_sel  = '1;
    if (SKIP_EMPTY != 0) begin
      for (int d = 0; d < DEPTH; d++) begin
        w_in_sel[d] = |bus.in_mask[d*SLICE +: SLICE];
        w_r_sel[d]  = |r_mask[d*SLICE +: SLICE];
      end
    end
  end

  assign w_in_pick   = pick(w_in_sel, 0);
  assign w_nxt_pick  = pick(w_r_sel, int'(r_idx) + 1);
  assign w_in_found  = w_in_pick[IDXW];
  assign w_in_idx    = w_in_pick[IDXW-1:0];
  assign w_nxt_found = w_nxt_pick[IDXW];
  assign w_nxt_idx   = w_nxt_pick[IDXW-1:0];

  assign w_fire     = r_out_valid & bus.out_ready;
  assign w_in_ready = !bus.flush & ((r_state == IDLE) | (w_fire & r_out_last));
  assign w_load     = bus.in_valid & w_in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_out_valid  <= 1'b0;
      r_out_last   <= 1'b0;
      r_empty_drop <= 1'b0;
      r_idx        <= '0;
    end else begin
      r_empty_drop <= 1'b0;
      if (bus.flush) begin
        r_state     <= IDLE;
        r_out_valid <= 1'b0;
        r_out_last  <= 1'b0;
        r_idx       <= '0;
      end else if (w_load) begin
        if (w_in_found) begin
          r_state     <= SHIFT;
          r_out_valid <= 1'b1;
          r_idx       <= w_in_idx;
          r_out_last  <= !any_after(w_in_sel, int'(w_in_idx));
        end else begin
          r_state      <= IDLE;
          r_out_valid  <= 1'b0;
          r_out_last   <= 1'b0;
          r_empty_drop <= 1'b1;
        end
      end else if (w_fire) begin
        if (r_out_last || !w_nxt_found) begin
          r_state     <= IDLE;
          r_out_valid <= 1'b0;
          r_out_last  <= 1'b0;
        end else begin
          r_idx      <= w_nxt_idx;
          r_out_last <= !any_after(w_r_sel, int'(w_nxt_idx));
        end
      end
    end
  end

  // Vector storage carries no reset; outputs are gated by out_valid instead.
  always_ff @(posedge clk) begin
    if (w_load) begin
      r_data <= bus.in_data;
      r_mask <= bus.in_mask;
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.out_valid  = r_out_valid;
  assign bus.out_idx    = r_idx;
  assign bus.out_last   = r_out_last;
  assign bus.empty_drop = r_empty_drop;
  assign bus.out_data   = r_out_valid ? r_data[int'(r_idx)*SLICE*WIDTH +: SLICE*WIDTH] : '0;
  assign bus.out_mask   = r_out_valid ? r_mask[int'(r_idx)*SLICE +: SLICE] : '0;
endmodule

// File: tb/tb_lane_serializer.sv
// Bench for lane_serializer: one instance without and one with empty-slice
// skipping, sharing stimulus, checked by tables, sequences and a queue model.
module tb_lane_serializer;
  localparam int WIDTH = 32;
  localparam int LANES = 64;
  localparam int SLICE = 16;
  localparam int DEPTH = LANES / SLICE;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   in_valid = 1'b0;
  logic [LANES*WIDTH-1:0] in_data = '0;
  logic [LANES-1:0]       in_mask = '0;
  logic                   flush = 1'b0;
  logic                   out_ready = 1'b1;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  lane_serializer_if #(.WIDTH(WIDTH), .LANES(LANES), .SLICE(SLICE)) if0 ();
  lane_serializer_if #(.WIDTH(WIDTH), .LANES(LANES), .SLICE(SLICE)) if1 ();

  assign if0.in_valid = in_valid;  assign if1.in_valid = in_valid;
  assign if0.in_data = in_data;    assign if1.in_data = in_data;
  assign if0.in_mask = in_mask;    assign if1.in_mask = in_mask;
  assign if0.flush = flush;        assign if1.flush = flush;
  assign if0.out_ready = out_ready; assign if1.out_ready = out_ready;

  lane_serializer #(.WIDTH(WIDTH), .LANES(LANES), .SLICE(SLICE), .SKIP_EMPTY(0)) dut0 (
    .clk(clk), .rst(rst), .bus(if0));
  lane_serializer #(.WIDTH(WIDTH), .LANES(LANES), .SLICE(SLICE), .SKIP_EMPTY(1)) dut1 (
    .clk(clk), .rst(rst), .bus(if1));

  typedef struct packed {
    logic                   rdy;
    logic                   vld;
    logic [SLICE*WIDTH-1:0] data;
    logic [SLICE-1:0]       mask;
    logic [1:0]             idx;
    logic                   last;
    logic                   drop;
  } obs_t;

  obs_t ob [2];
  assign ob[0] = {if0.in_ready, if0.out_valid, if0.out_data, if0.out_mask, if0.out_idx, if0.out_last, if0.empty_drop};
  assign ob[1] = {if1.in_ready, if1.out_valid, if1.out_data, if1.out_mask, if1.out_idx, if1.out_last, if1.empty_drop};

  // Reference model: each accepted vector becomes a list of slice numbers to emit.
  int                     m_list [2][4];
  int                     m_cnt  [2];
  int                     m_head [2];
  logic [LANES*WIDTH-1:0] m_data [2];
  logic [LANES-1:0]       m_mask [2];
  bit                     m_drop [2];
  bit                     m_zero [2];

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [LANES*WIDTH-1:0] fill(input logic [15:0] base);
    logic [LANES*WIDTH-1:0] r;
    for (int i = 0; i < LANES; i++) r[i*WIDTH +: WIDTH] = {base, 16'(i)};
    return r;
  endfunction

  function automatic logic [SLICE*WIDTH-1:0] exp_beat(input logic [15:0] base, input int idx);
    logic [SLICE*WIDTH-1:0] r;
    for (int j = 0; j < SLICE; j++) r[j*WIDTH +: WIDTH] = {base, 16'(idx*SLICE + j)};
    return r;
  endfunction

  function automatic bit m_valid(input int s);
    return m_head[s] < m_cnt[s];
  endfunction

  function automatic bit m_last(input int s);
    return m_valid(s) && (m_head[s] == m_cnt[s] - 1);
  endfunction

  function automatic bit m_rdy(input int s);
    return !flush && (!m_valid(s) || (out_ready && m_last(s)));
  endfunction

  task automatic model_update();
    for (int s = 0; s < 2; s++) begin
      bit v, r;
      v = m_valid(s);
      r = m_rdy(s);
      m_drop[s] = 1'b0;
      if (rst || flush) begin
        m_cnt[s] = 0; m_head[s] = 0; m_zero[s] = 1'b1;
      end else begin
        if (v && out_ready) m_head[s]++;
        if (in_valid && r) begin
          m_cnt[s] = 0; m_head[s] = 0; m_zero[s] = 1'b0;
          for (int k = 0; k < DEPTH; k++)
            if (s == 0 || in_mask[k*SLICE +: SLICE] != '0) begin
              m_list[s][m_cnt[s]] = k;
              m_cnt[s]++;
            end
          m_data[s] = in_data;
          m_mask[s] = in_mask;
          if (m_cnt[s] == 0) m_drop[s] = 1'b1;
        end
      end
    end
  endtask

  task automatic pre_half();
    @(negedge clk);
    for (int s = 0; s < 2; s++) chk($sformatf("d%0d_in_ready", s), ob[s].rdy, m_rdy(s));
  endtask

  task automatic post_half();
    @(posedge clk);
    model_update();
    #1;
    for (int s = 0; s < 2; s++) begin
      bit v;
      int k;
      v = m_valid(s);
      chk($sformatf("d%0d_out_valid", s), ob[s].vld, v);
      chk($sformatf("d%0d_empty_drop", s), ob[s].drop, m_drop[s]);
      if (v) begin
        k = m_list[s][m_head[s]];
        chk($sformatf("d%0d_out_idx", s), ob[s].idx, k);
        chk($sformatf("d%0d_out_last", s), ob[s].last, m_last(s));
        chk($sformatf("d%0d_out_data", s), ob[s].data, m_data[s][k*SLICE*WIDTH +: SLICE*WIDTH]);
        chk($sformatf("d%0d_out_mask", s), ob[s].mask, m_mask[s][k*SLICE +: SLICE]);
      end else if (m_zero[s]) begin
        chk($sformatf("d%0d_idle_idx", s), ob[s].idx, 0);
        chk($sformatf("d%0d_idle_last", s), ob[s].last, 0);
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (2) begin pre_half(); post_half(); end
    rst = 1'b0;
  endtask

  function automatic logic [LANES-1:0] rand_mask();
    logic [LANES-1:0] m;
    int r;
    for (int k = 0; k < DEPTH; k++) begin
      r = $urandom_range(0, 3);
      m[k*SLICE +: SLICE] = (r == 0) ? 16'h0 : (r == 1) ? 16'hFFFF : 16'($urandom);
    end
    if ($urandom_range(0, 7) == 0) m = '0;
    return m;
  endfunction

  function automatic logic [LANES*WIDTH-1:0] rand_data();
    logic [LANES*WIDTH-1:0] d;
    for (int i = 0; i < LANES; i++) d[i*WIDTH +: WIDTH] = $urandom;
    return d;
  endfunction

  typedef struct {
    int          dut;
    bit          rst_before;
    bit          iv;
    logic [63:0] mask;
    logic [15:0] base;
    bit          ordy;
    bit          e_rdy;
    bit          e_valid;
    int          e_idx;
    bit          e_last;
    logic [15:0] e_mask;
    bit          e_drop;
    logic [15:0] e_base;
  } vec_t;

  function automatic vec_t mkv(input int dut, input bit rb, input bit iv, input logic [63:0] m,
                               input logic [15:0] b, input bit ordy, input bit er, input bit ev,
                               input int ei, input bit el, input logic [15:0] em, input bit ed,
                               input logic [15:0] eb);
    vec_t v;
    v.dut = dut; v.rst_before = rb; v.iv = iv; v.mask = m; v.base = b; v.ordy = ordy;
    v.e_rdy = er; v.e_valid = ev; v.e_idx = ei; v.e_last = el; v.e_mask = em;
    v.e_drop = ed; v.e_base = eb;
    return v;
  endfunction

  initial begin
    vec_t tbl[$];
    localparam logic [63:0] F  = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] M2 = 64'h0000_FFFF_0000_0001;

    // Full-mask sweep, no skipping
    tbl.push_back(mkv(0, 1, 1, F, 16'h0011, 1, 1, 1, 0, 0, 16'hFFFF, 0, 16'h0011));
    tbl.push_back(mkv(0, 0, 0, F, 16'h0000, 1, 0, 1, 1, 0, 16'hFFFF, 0, 16'h0011));
    tbl.push_back(mkv(0, 0, 0, F, 16'h0000, 1, 0, 1, 2, 0, 16'hFFFF, 0, 16'h0011));
    tbl.push_back(mkv(0, 0, 0, F, 16'h0000, 1, 0, 1, 3, 1, 16'hFFFF, 0, 16'h0011));
    tbl.push_back(mkv(0, 0, 0, F, 16'h0000, 1, 1, 0, 0, 0, 16'h0000, 0, 16'h0000));
    // Sparse mask with skipping
    tbl.push_back(mkv(1, 1, 1, M2, 16'h0022, 1, 1, 1, 0, 0, 16'h0001, 0, 16'h0022));
    tbl.push_back(mkv(1, 0, 0, M2, 16'h0000, 1, 0, 1, 2, 1, 16'hFFFF, 0, 16'h0022));
    tbl.push_back(mkv(1, 0, 0, M2, 16'h0000, 1, 1, 0, 0, 0, 16'h0000, 0, 16'h0000));
    // All-zero mask with skipping
    tbl.push_back(mkv(1, 1, 1, 64'h0, 16'h0033, 1, 1, 0, 0, 0, 16'h0000, 1, 16'h0000));
    tbl.push_back(mkv(1, 0, 0, 64'h0, 16'h0000, 1, 1, 0, 0, 0, 16'h0000, 0, 16'h0000));
    tbl.push_back(mkv(1, 0, 0, 64'h0, 16'h0000, 1, 1, 0, 0, 0, 16'h0000, 0, 16'h0000));
    // Stall at idx 1 for three cycles
    tbl.push_back(mkv(0, 1, 1, F, 16'h0044, 1, 1, 1, 0, 0, 16'hFFFF, 0, 16'h0044));
    tbl.push_back(mkv(0, 0, 0, F, 16'h0000, 1, 0, 1, 1, 0, 16'hFFFF, 0, 16'h0044));
    tbl.push_back(mkv(0, 0, 0, F, 16'h0000, 0, 0, 1, 1, 0, 16'hFFFF, 0, 16'h0044));
    tbl.push_back(mkv(0, 0, 0, F, 16'h0000, 0, 0, 1, 1, 0, 16'hFFFF, 0, 16'h0044));
    tbl.push_back(mkv(0, 0, 0, F, 16'h0000, 0, 0, 1, 1, 0, 16'hFFFF, 0, 16'h0044));
    tbl.push_back(mkv(0, 0, 0, F, 16'h0000, 1, 0, 1, 2, 0, 16'hFFFF, 0, 16'h0044));
    // Back-to-back load on the final beat
    tbl.push_back(mkv(0, 1, 1, F, 16'h0055, 1, 1, 1, 0, 0, 16'hFFFF, 0, 16'h0055));
    tbl.push_back(mkv(0, 0, 0, F, 16'h0000, 1, 0, 1, 1, 0, 16'hFFFF, 0, 16'h0055));
    tbl.push_back(mkv(0, 0, 0, F, 16'h0000, 1, 0, 1, 2, 0, 16'hFFFF, 0, 16'h0055));
    tbl.push_back(mkv(0, 0, 0, F, 16'h0000, 1, 0, 1, 3, 1, 16'hFFFF, 0, 16'h0055));
    tbl.push_back(mkv(0, 0, 1, F, 16'h0066, 1, 1, 1, 0, 0, 16'hFFFF, 0, 16'h0066));
    tbl.push_back(mkv(0, 0, 0, F, 16'h0000, 1, 0, 1, 1, 0, 16'hFFFF, 0, 16'h0066));

    // Reset values
    repeat (2) begin pre_half(); post_half(); end
    for (int s = 0; s < 2; s++) begin
      chk($sformatf("rst%0d_valid", s), ob[s].vld, 0);
      chk($sformatf("rst%0d_data", s), ob[s].data, 0);
      chk($sformatf("rst%0d_mask", s), ob[s].mask, 0);
      chk($sformatf("rst%0d_idx", s), ob[s].idx, 0);
      chk($sformatf("rst%0d_last", s), ob[s].last, 0);
      chk($sformatf("rst%0d_drop", s), ob[s].drop, 0);
    end
    rst = 1'b0;
    pre_half();
    chk("rst_in_ready0", ob[0].rdy, 1);
    chk("rst_in_ready1", ob[1].rdy, 1);
    post_half();

    for (int i = 0; i < tbl.size(); i++) begin
      vec_t t;
      t = tbl[i];
      if (t.rst_before) do_reset();
      in_valid = t.iv; in_mask = t.mask; in_data = fill(t.base); out_ready = t.ordy; flush = 1'b0;
      pre_half();
      chk($sformatf("t%0d_in_ready", i), ob[t.dut].rdy, t.e_rdy);
      post_half();
      chk($sformatf("t%0d_out_valid", i), ob[t.dut].vld, t.e_valid);
      chk($sformatf("t%0d_empty_drop", i), ob[t.dut].drop, t.e_drop);
      if (t.e_valid) begin
        chk($sformatf("t%0d_out_idx", i), ob[t.dut].idx, t.e_idx);
        chk($sformatf("t%0d_out_last", i), ob[t.dut].last, t.e_last);
        chk($sformatf("t%0d_out_mask", i), ob[t.dut].mask, t.e_mask);
        chk($sformatf("t%0d_out_data", i), ob[t.dut].data, exp_beat(t.e_base, t.e_idx));
      end
    end

    // Flush at idx 2 with a competing load
    do_reset();
    in_valid = 1'b1; in_mask = '1; in_data = fill(16'h0077); out_ready = 1'b1;
    pre_half(); post_half();
    in_valid = 1'b0;
    repeat (2) begin pre_half(); post_half(); end
    chk("fl_idx2", ob[0].idx, 2);
    flush = 1'b1; in_valid = 1'b1; in_data = fill(16'h0088);
    pre_half();
    chk("fl_in_ready_low", ob[0].rdy, 0);
    post_half();
    chk("fl_valid", ob[0].vld, 0);
    chk("fl_idx", ob[0].idx, 0);
    chk("fl_last", ob[0].last, 0);
    flush = 1'b0; in_valid = 1'b0;
    pre_half();
    chk("fl_in_ready_high", ob[0].rdy, 1);
    post_half();
    in_valid = 1'b1; in_data = fill(16'h0099);
    pre_half(); post_half();
    in_valid = 1'b0;
    chk("fl_new_valid", ob[0].vld, 1);
    chk("fl_new_idx", ob[0].idx, 0);
    chk("fl_new_data", ob[0].data, exp_beat(16'h0099, 0));

    // Reset at idx 1
    do_reset();
    in_valid = 1'b1; in_mask = '1; in_data = fill(16'h00AA); out_ready = 1'b1;
    pre_half(); post_half();
    in_valid = 1'b0;
    pre_half(); post_half();
    chk("rm_idx1", ob[0].idx, 1);
    rst = 1'b1;
    pre_half(); post_half();
    rst = 1'b0;
    chk("rm_valid", ob[0].vld, 0);
    chk("rm_idx", ob[0].idx, 0);
    chk("rm_data", ob[0].data, 0);
    pre_half();
    chk("rm_in_ready", ob[0].rdy, 1);
    post_half();
    in_valid = 1'b1; in_data = fill(16'h00BB);
    pre_half(); post_half();
    in_valid = 1'b0;
    chk("rm_new_idx", ob[0].idx, 0);
    chk("rm_new_data", ob[0].data, exp_beat(16'h00BB, 0));

    // Randomized traffic against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      rst       = ($urandom_range(0, 199) == 0);
      flush     = ($urandom_range(0, 29) == 0);
      in_valid  = ($urandom_range(0, 1) == 1);
      out_ready = ($urandom_range(0, 9) < 7);
      in_mask   = rand_mask();
      in_data   = rand_data();
      pre_half();
      post_half();
    end
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
